// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - CPU data-side bridge: data memory / LED / switch / timer decode.
// Optional countdown timer with interrupt is built only when BRIDGE_TIMER_EN is defined.
module mem_io_bridge #(
  parameter int DM_AW = 10,
  parameter int TMR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             dm_we,
  input  logic [31:0]      dm_rdata,
  input  logic [15:0]      sw_i,
  output logic [15:0]      led_o,
  output logic             irq
);

  logic        io_sel;
  logic        io_we;
  logic [5:0]  io_word;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [31:0] io_rdata;
  logic [31:0] tmr_rdata;
  logic        unused_addr;

  assign io_sel      = (addr[31:8] == 24'h00007F);
  assign io_word     = addr[7:2];
  assign io_we       = we & io_sel;
  assign dm_we       = we & ~io_sel;
  assign dm_addr     = addr[DM_AW+1:2];
  assign dm_wdata    = wdata;
  assign unused_addr = ^addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_o   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_i;
      sw_sync <= sw_meta;
      if (io_we && io_word == 6'h00) led_o <= wdata[15:0];
    end
  end

  always_comb begin
    io_rdata = tmr_rdata;
    case (io_word)
      6'h00:   io_rdata = {16'h0000, led_o};
      6'h01:   io_rdata = {16'h0000, sw_sync};
      default: io_rdata = tmr_rdata;
    endcase
  end

  assign rdata = io_sel ? io_rdata : dm_rdata;

`ifdef BRIDGE_TIMER_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COUNT, ST_EXPIRE} tmr_state_t;

  tmr_state_t       state, state_nxt;
  logic             en, en_nxt, reload, reload_nxt, ie, ie_nxt, done, done_nxt;
  logic [TMR_W-1:0] preset, count, count_nxt;
  logic [31:0]      preset_ext, count_ext;
  logic             ctrl_wr, preset_wr;

  assign ctrl_wr   = io_we && io_word == 6'h04;
  assign preset_wr = io_we && io_word == 6'h05;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      en     <= 1'b0;
      reload <= 1'b0;
      ie     <= 1'b0;
      done   <= 1'b0;
      preset <= '0;
      count  <= '0;
      irq    <= 1'b0;
    end else begin
      state  <= state_nxt;
      en     <= en_nxt;
      reload <= reload_nxt;
      ie     <= ie_nxt;
      done   <= done_nxt;
      count  <= count_nxt;
      irq    <= done_nxt & ie_nxt;
      if (preset_wr) preset <= wdata[TMR_W-1:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    en_nxt     = en;
    reload_nxt = reload;
    ie_nxt     = ie;
    done_nxt   = done;
    count_nxt  = count;
    case (state)
      ST_IDLE: ;
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (count != '0) count_nxt = count - TMR_W'(1);
        else             state_nxt = ST_EXPIRE;
      end
      ST_EXPIRE: begin
        done_nxt = 1'b1;
        if (reload) begin
          state_nxt = ST_LOAD;
        end else begin
          en_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A CTRL write overrides whatever the timer was doing this cycle, including expiry.
    if (ctrl_wr) begin
      en_nxt     = wdata[0];
      reload_nxt = wdata[1];
      ie_nxt     = wdata[3];
      done_nxt   = 1'b0;
      count_nxt  = count;
      state_nxt  = wdata[0] ? ST_LOAD : ST_IDLE;
    end
  end

  always_comb begin
    preset_ext = '0;
    count_ext  = '0;
    preset_ext[TMR_W-1:0] = preset;
    count_ext[TMR_W-1:0]  = count;
    case (io_word)
      6'h04:   tmr_rdata = {27'd0, done, ie, 1'b0, reload, en};
      6'h05:   tmr_rdata = preset_ext;
      6'h06:   tmr_rdata = count_ext;
      default: tmr_rdata = '0;
    endcase
  end
`else
  logic [TMR_W-1:0] unused_tmr;

  assign unused_tmr = '0;
  assign tmr_rdata  = '0;
  assign irq        = 1'b0;
`endif

endmodule
